mask_pixel_streamer: RTL and testbench
======================================

// Module: mask_pixel_streamer
// PURPOSE
// - Producer side of the (x_in, y_in, frame_valid_in) coordinate stream consumed by connected_components.
// - Raster-scans a 1-bit foreground mask held in a BRAM frame buffer, WIDTH x HEIGHT.
// - Emits the (x, y) of each set pixel, one per cycle, honouring the consumer's busy.
// - Pulses frame_valid_out once the whole frame has been delivered.
// PARAMETERS
// WIDTH         320  mask width in pixels
// HEIGHT        180  mask height in pixels
// READ_LATENCY  2    BRAM cycles from mem_addr_out to mem_data_in (1..3)
// FIFO_DEPTH    4    output buffer entries; must be >= READ_LATENCY+1, power of 2
// PORTS
// clk_in           in   1                      system clock
// rst_in           in   1                      asynchronous, active-high reset
// start_in         in   1                      pulse: begin scanning a frame
// busy_in          in   1                      consumer busy; no pixel may be emitted while high
// mem_addr_out     out  $clog2(WIDTH*HEIGHT)   BRAM read address, = y*WIDTH + x
// mem_data_in      in   1                      mask bit, READ_LATENCY cycles after its address
// x_out            out  11                     pixel column, 0..WIDTH-1
// y_out            out  10                     pixel row, 0..HEIGHT-1
// pixel_valid_out  out  1                      x_out/y_out hold a foreground pixel this cycle
// frame_valid_out  out  1                      one-cycle pulse: frame complete
// busy_out         out  1                      scan in progress
// pixel_count_out  out  $clog2(WIDTH*HEIGHT)+1 foreground pixels emitted in the current/last frame
// BEHAVIOUR
// - Reset (asynchronous, active-high) zeroes every output, counter, FIFO pointer and in-flight tag.
//   FSM returns to IDLE; asserting reset mid-frame abandons the frame with no frame_valid_out pulse.
// - FSM states:
//   IDLE: start_in=1 -> SCAN; clear pixel_count_out, x/y/addr counters to 0; busy_out=1 from next cycle.
//   SCAN: one address issued per cycle when credit is available; after address WIDTH*HEIGHT-1 -> DRAIN.
//   DRAIN: wait until in-flight=0 and FIFO empty -> DONE.
//   DONE: frame_valid_out=1 for exactly one cycle, busy_out=0 -> IDLE.
// - start_in is ignored outside IDLE. A start_in in the same cycle as DONE is also ignored.
// - Address/coordinate generation:
//   - x increments and wraps WIDTH-1 -> 0, then y increments; addr increments by 1.
//   - No multiplier is used.
// - Read pipeline:
//   - A READ_LATENCY-deep shift register carries {valid, x, y} alongside each issued address.
//   - When the tag exits and mem_data_in=1, {x,y} is pushed into the FIFO; a 0 bit is discarded.
// - Credit rule:
//   - Issue only if (in-flight reads + FIFO occupancy) < FIFO_DEPTH.
//   - The FIFO therefore never overflows and no BRAM data is ever dropped.
//   - Issuing stops only for lack of credit, never directly on busy_in.
// - Output:
//   - When the FIFO is non-empty and busy_in=0, pop one entry that cycle.
//   - Drive x_out/y_out with it and pulse pixel_valid_out for one cycle.
//   - The output is registered: 1-cycle pop-to-output latency.
//   - When pixel_valid_out=0, x_out/y_out hold their last value.
//   - pixel_count_out increments on each pixel_valid_out.
// - Simultaneous push and pop in one cycle: occupancy unchanged. A push into an empty FIFO is poppable the next cycle.
// - Throughput: 1 pixel/cycle sustained when busy_in=0. Scanning an empty mask takes WIDTH*HEIGHT+READ_LATENCY+O(1) cycles.
// - frame_valid_out asserts strictly after the last pixel_valid_out of the frame, never in the same cycle.
// - pixel_count_out holds its final value until the next accepted start_in.
// TESTING
// - Use WIDTH=4, HEIGHT=3, READ_LATENCY=2, with a BRAM model.
// 1 All-zero mask, start_in pulse -> no pixel_valid_out; one frame_valid_out; pixel_count_out=0; busy_out high for ~14 cycles.
// 2 Bits set at (0,0),(3,0),(1,2), busy_in=0 ->
//   pixels (0,0),(3,0),(1,2) in order; count=3; frame_valid_out after (1,2).
// 3 All-ones mask, busy_in=0 -> 12 pixels on consecutive cycles; x wraps 3->0 with y+1; count=12.
// 4 All-ones mask, busy_in toggled 1,1,0 repeating -> still 12 ordered pixels.
//   No pixel_valid_out while busy_in=1; assert FIFO occupancy <= 4.
// 5 Reset asserted asynchronously mid-SCAN -> outputs 0 immediately.
//   No frame_valid_out; a new start_in scans a full correct frame.
// 6 start_in re-pulsed during SCAN -> ignored; exactly one frame_valid_out; count unchanged from case 3.

Source files
------------

// File: rtl/mask_pixel_streamer_if.sv
// Pixel stream and BRAM read bus between mask_pixel_streamer and its neighbours.
// master = streamer side, slave = consumer/BRAM side.
interface mask_pixel_streamer_if #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 180
);
    localparam int unsigned AddrW = $clog2(WIDTH * HEIGHT);

    logic [AddrW-1:0] mem_addr_out;
    logic             mem_data_in;
    logic [10:0]      x_out;
    logic [9:0]       y_out;
    logic             pixel_valid_out;
    logic             busy_in;

    modport master (
        output mem_addr_out,
        output x_out,
        output y_out,
        output pixel_valid_out,
        input  mem_data_in,
        input  busy_in
    );

    modport slave (
        input  mem_addr_out,
        input  x_out,
        input  y_out,
        input  pixel_valid_out,
        output mem_data_in,
        output busy_in
    );
endinterface

// File: rtl/mask_pixel_streamer.sv
// Raster-scans a 1-bit mask in BRAM and streams the (x, y) of each set pixel.
// Reads are credit-limited so the output FIFO can absorb every in-flight BRAM word.
module mask_pixel_streamer #(
    parameter int unsigned WIDTH        = 320,
    parameter int unsigned HEIGHT       = 180,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    mask_pixel_streamer_if.master         px,
    output logic                          frame_valid_out,
    output logic                          busy_out,
    output logic [$clog2(WIDTH*HEIGHT):0] pixel_count_out
);
    localparam int unsigned NumPix = WIDTH * HEIGHT;
    localparam int unsigned AddrW  = $clog2(NumPix);
    localparam int unsigned CntW   = AddrW + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW   = PtrW + 1;
    localparam int unsigned CredW  = OccW + 1;

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e           state_q;
    logic [10:0]      x_q;
    logic [9:0]       y_q;
    logic [AddrW-1:0] addr_q;
    logic             fv_q;
    logic             busy_q;
    logic [CntW-1:0]  count_q;

    // Tag pipeline: tracks which coordinate each returning BRAM bit belongs to.
    logic             tag_v_q [READ_LATENCY];
    logic [10:0]      tag_x_q [READ_LATENCY];
    logic [9:0]       tag_y_q [READ_LATENCY];
    logic [OccW-1:0]  inflight_q, inflight_d;

    logic [10:0]      fifo_x_q [FIFO_DEPTH];
    logic [9:0]       fifo_y_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]  occ_q, occ_d;

    logic             pv_q;
    logic [10:0]      x_out_q;
    logic [9:0]       y_out_q;

    logic             issue, tag_exit, push, pop, last_addr, drained;
    logic [CredW-1:0] credit_used;

    // Credit, push/pop decisions and occupancy bookkeeping.
    always_comb begin
        credit_used = CredW'(inflight_q) + CredW'(occ_q);
        issue       = (state_q == StScan) && (credit_used < CredW'(FIFO_DEPTH));
        tag_exit    = tag_v_q[READ_LATENCY-1];
        push        = tag_exit && px.mem_data_in;
        pop         = (occ_q != '0) && !px.busy_in;
        last_addr   = (addr_q == AddrW'(NumPix - 1));
        drained     = (inflight_q == '0) && (occ_q == '0);
        inflight_d  = inflight_q + OccW'(issue) - OccW'(tag_exit);
        occ_d       = occ_q + OccW'(push) - OccW'(pop);
    end

    // Control FSM with scan counters, frame pulse, busy flag and pixel count.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            fv_q <= 1'b0;
            if (pop) count_q <= count_q + CntW'(1);
            unique case (state_q)
                StIdle: begin
                    if (start_in) begin
                        state_q <= StScan;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                    end
                end
                StScan: begin
                    if (issue) begin
                        if (last_addr) begin
                            state_q <= StDrain;
                        end else begin
                            addr_q <= addr_q + AddrW'(1);
                            if (x_q == 11'(WIDTH - 1)) begin
                                x_q <= '0;
                                y_q <= y_q + 10'd1;
                            end else begin
                                x_q <= x_q + 11'd1;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state_q <= StDone;
                        fv_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: state_q <= StIdle;
            endcase
        end
    end

    // Shift the {valid, x, y} tag alongside each outstanding read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_v_q[i] <= 1'b0;
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
            inflight_q <= '0;
        end else begin
            tag_v_q[0] <= issue;
            tag_x_q[0] <= x_q;
            tag_y_q[0] <= y_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_x_q[i] <= tag_x_q[i-1];
                tag_y_q[i] <= tag_y_q[i-1];
            end
            inflight_q <= inflight_d;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            occ_q <= occ_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_x_q[wr_ptr_q] <= tag_x_q[READ_LATENCY-1];
            fifo_y_q[wr_ptr_q] <= tag_y_q[READ_LATENCY-1];
        end
    end

    // Registered output stage; coordinates hold when nothing is popped.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pv_q    <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else begin
            pv_q <= pop;
            if (pop) begin
                x_out_q <= fifo_x_q[rd_ptr_q];
                y_out_q <= fifo_y_q[rd_ptr_q];
            end
        end
    end

    assign px.mem_addr_out    = addr_q;
    assign px.x_out           = x_out_q;
    assign px.y_out           = y_out_q;
    assign px.pixel_valid_out = pv_q;
    assign frame_valid_out    = fv_q;
    assign busy_out           = busy_q;
    assign pixel_count_out    = count_q;
endmodule

// File: tb/tb_mask_pixel_streamer.sv
// Directed bench for mask_pixel_streamer on a 4x3 mask with a 2-cycle BRAM model.
module tb_mask_pixel_streamer;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic       frame_valid_out;
    logic       busy_out;
    logic [4:0] pixel_count_out;

    mask_pixel_streamer_if #(.WIDTH(W), .HEIGHT(H)) px ();

    mask_pixel_streamer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .READ_LATENCY (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .px              (px),
        .frame_valid_out (frame_valid_out),
        .busy_out        (busy_out),
        .pixel_count_out (pixel_count_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: two-cycle read latency.
    logic mask [N];
    logic rd1, rd2;
    always @(posedge clk_in) begin
        rd1 <= mask[px.mem_addr_out];
        rd2 <= rd1;
    end
    assign px.mem_data_in = rd2;

    int   checks = 0;
    int   passed = 0;
    int   cyc, fv_cnt, busy_cycles, pv_after_fv, busy_viol, occ_viol, first_pv, last_pv;
    int   got_x[$];
    int   got_y[$];
    logic busy_cur;

    task automatic clear_mon();
        got_x.delete();
        got_y.delete();
        cyc = 0; fv_cnt = 0; busy_cycles = 0; pv_after_fv = 0;
        busy_viol = 0; occ_viol = 0; first_pv = -1; last_pv = -1;
    endtask

    // One cycle: sample at the falling edge, then drive busy_in for the next cycle.
    task automatic step(input logic b);
        @(negedge clk_in);
        cyc++;
        if (frame_valid_out) begin
            fv_cnt++;
            if (px.pixel_valid_out) pv_after_fv++;
        end else if (px.pixel_valid_out && fv_cnt > 0) begin
            pv_after_fv++;
        end
        if (px.pixel_valid_out) begin
            got_x.push_back(int'(px.x_out));
            got_y.push_back(int'(px.y_out));
            if (first_pv < 0) first_pv = cyc;
            last_pv = cyc;
            if (busy_cur) busy_viol++;
        end
        if (busy_out) busy_cycles++;
        if (dut.occ_q > 4) occ_viol++;
        px.busy_in = b;
        busy_cur   = b;
    endtask

    function automatic logic busy_pat(input int mode, input int i);
        return (mode == 1) ? ((i % 3) != 2) : 1'b0;
    endfunction

    task automatic run_frame(input int mode, input int restart_at);
        clear_mon();
        start_in = 1'b1;
        step(busy_pat(mode, 0));
        start_in = 1'b0;
        for (int i = 1; i < 300 && fv_cnt == 0; i++) begin
            start_in = (i == restart_at);
            step(busy_pat(mode, i));
        end
        start_in = 1'b0;
        checks++;
        if (fv_cnt == 0) $display("FAIL frame_timeout: frame_valid_out seen %0d times, want 1", fv_cnt);
        else passed++;
        repeat (6) step(1'b0);
    endtask

    task automatic set_mask(input logic v);
        for (int i = 0; i < N; i++) mask[i] = v;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; start_in = 1'b0; px.busy_in = 1'b0; busy_cur = 1'b0;
        set_mask(1'b0);
        repeat (2) @(negedge clk_in);
        checks++; if (px.pixel_valid_out !== 1'b0) $display("FAIL reset_pv: got %b want 0", px.pixel_valid_out); else passed++;
        checks++; if (frame_valid_out !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid_out); else passed++;
        checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else passed++;
        checks++; if (pixel_count_out !== 5'd0) $display("FAIL reset_count: got %0d want 0", pixel_count_out); else passed++;
        checks++; if (px.x_out !== 11'd0 || px.y_out !== 10'd0) $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", px.x_out, px.y_out); else passed++;
        checks++; if (px.mem_addr_out !== 4'd0) $display("FAIL reset_addr: got %0d want 0", px.mem_addr_out); else passed++;
        rst_in = 1'b0;
        step(1'b0);
    endtask

    task automatic test_empty_mask();
        set_mask(1'b0);
        run_frame(0, -1);
        checks++; if (got_x.size() != 0) $display("FAIL empty_pixels: got %0d want 0", got_x.size()); else passed++;
        checks++; if (fv_cnt != 1) $display("FAIL empty_fv_count: got %0d want 1", fv_cnt); else passed++;
        checks++; if (pixel_count_out !== 5'd0) $display("FAIL empty_count: got %0d want 0", pixel_count_out); else passed++;
        checks++; if (busy_cycles < 13 || busy_cycles > 16) $display("FAIL empty_busy_len: got %0d want 13..16", busy_cycles); else passed++;
    endtask

    task automatic test_sparse();
        int  ex[3];
        int  ey[3];
        logic ok;
        ex = '{0, 3, 1};
        ey = '{0, 0, 2};
        set_mask(1'b0);
        mask[0] = 1'b1; mask[3] = 1'b1; mask[9] = 1'b1;
        run_frame(0, -1);
        ok = (got_x.size() == 3);
        if (ok) for (int i = 0; i < 3; i++) if (got_x[i] != ex[i] || got_y[i] != ey[i]) ok = 1'b0;
        checks++; if (!ok) $display("FAIL sparse_order: got %0d pixels, want (0,0),(3,0),(1,2)", got_x.size()); else passed++;
        checks++; if (pixel_count_out !== 5'd3) $display("FAIL sparse_count: got %0d want 3", pixel_count_out); else passed++;
        checks++; if (fv_cnt != 1 || pv_after_fv != 0) $display("FAIL sparse_fv: got fv=%0d late_pv=%0d want 1,0", fv_cnt, pv_after_fv); else passed++;
    endtask

    task automatic test_all_ones();
        logic ok;
        set_mask(1'b1);
        run_frame(0, -1);
        ok = (got_x.size() == N);
        if (ok) for (int i = 0; i < N; i++) if (got_x[i] != i % W || got_y[i] != i / W) ok = 1'b0;
        checks++; if (!ok) $display("FAIL ones_order: got %0d pixels, want 12 in raster order", got_x.size()); else passed++;
        checks++; if (last_pv - first_pv != N - 1) $display("FAIL ones_rate: got span %0d want 11", last_pv - first_pv); else passed++;
        checks++; if (pixel_count_out !== 5'd12) $display("FAIL ones_count: got %0d want 12", pixel_count_out); else passed++;
        checks++; if (px.x_out !== 11'd3 || px.y_out !== 10'd2) $display("FAIL ones_hold: got (%0d,%0d) want (3,2)", px.x_out, px.y_out); else passed++;
        checks++; if (fv_cnt != 1 || pv_after_fv != 0) $display("FAIL ones_fv: got fv=%0d late_pv=%0d want 1,0", fv_cnt, pv_after_fv); else passed++;
    endtask

    task automatic test_busy_toggle();
        logic ok;
        set_mask(1'b1);
        run_frame(1, -1);
        ok = (got_x.size() == N);
        if (ok) for (int i = 0; i < N; i++) if (got_x[i] != i % W || got_y[i] != i / W) ok = 1'b0;
        checks++; if (!ok) $display("FAIL busy_order: got %0d pixels, want 12 in raster order", got_x.size()); else passed++;
        checks++; if (busy_viol != 0) $display("FAIL busy_respect: got %0d pops under busy want 0", busy_viol); else passed++;
        checks++; if (occ_viol != 0) $display("FAIL busy_occ: got %0d cycles over 4 want 0", occ_viol); else passed++;
        checks++; if (pixel_count_out !== 5'd12) $display("FAIL busy_count: got %0d want 12", pixel_count_out); else passed++;
    endtask

    task automatic test_async_reset();
        logic ok;
        set_mask(1'b1);
        clear_mon();
        start_in = 1'b1;
        step(1'b0);
        start_in = 1'b0;
        repeat (7) step(1'b0);
        #2 rst_in = 1'b1;
        #1;
        checks++; if (px.pixel_valid_out !== 1'b0 || busy_out !== 1'b0) $display("FAIL arst_flags: got pv=%b busy=%b want 0,0", px.pixel_valid_out, busy_out); else passed++;
        checks++; if (pixel_count_out !== 5'd0 || px.mem_addr_out !== 4'd0) $display("FAIL arst_regs: got count=%0d addr=%0d want 0,0", pixel_count_out, px.mem_addr_out); else passed++;
        @(negedge clk_in);
        rst_in = 1'b0;
        clear_mon();
        repeat (20) step(1'b0);
        checks++; if (fv_cnt != 0 || got_x.size() != 0) $display("FAIL arst_quiet: got fv=%0d pixels=%0d want 0,0", fv_cnt, got_x.size()); else passed++;
        run_frame(0, -1);
        ok = (got_x.size() == N);
        if (ok) for (int i = 0; i < N; i++) if (got_x[i] != i % W || got_y[i] != i / W) ok = 1'b0;
        checks++; if (!ok || pixel_count_out !== 5'd12) $display("FAIL arst_rescan: got %0d pixels count=%0d want 12,12", got_x.size(), pixel_count_out); else passed++;
    endtask

    task automatic test_restart_ignored();
        set_mask(1'b1);
        run_frame(0, 4);
        checks++; if (fv_cnt != 1) $display("FAIL restart_fv: got %0d want 1", fv_cnt); else passed++;
        checks++; if (pixel_count_out !== 5'd12 || got_x.size() != N) $display("FAIL restart_count: got count=%0d pixels=%0d want 12,12", pixel_count_out, got_x.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_empty_mask();
        test_sparse();
        test_all_ones();
        test_busy_toggle();
        test_async_reset();
        test_restart_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
